// File: rtl/bpred_update_queue.sv
// Purpose : in-order queue of predicted branches; on resolve, pops the oldest entry and
//           emits a registered predictor update plus a front-end redirect on mispredict.
// Latency : update/redirect appear one cycle after the resolving cycle.
// Backpr. : queue_full=1 drops pushes (err_overflow) unless a non-miss resolve frees a slot
//           in the same cycle; a resolve on an empty queue is ignored (err_underflow).
// Ports   : fetch_* push side; exe_* resolve side; execute_bpredictor_* registered update;
//           fetch_redirect/_PC registered redirect; err_* sticky flags; stats_* counters.
// Option  : define BPRED_UQ_STATS_EN to enable stats_resolved/stats_miss counters,
//           otherwise those ports are tied to 0.
module bpred_update_queue #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 96,
   parameter int META_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_push,
   input  logic [31:0]       fetch_PC4,
   input  logic [31:0]       fetch_p_target,
   input  logic              fetch_p_dir,
   input  logic [DATA_W-1:0] fetch_data,
   input  logic [META_W-1:0] fetch_meta,
   output logic              queue_full,
   input  logic              exe_resolve,
   input  logic              exe_dir,
   input  logic [31:0]       exe_target,
   output logic              execute_bpredictor_update,
   output logic              execute_bpredictor_dir,
   output logic              execute_bpredictor_miss,
   output logic              execute_bpredictor_recover_ras,
   output logic [31:0]       execute_bpredictor_PC4,
   output logic [31:0]       execute_bpredictor_target,
   output logic [DATA_W-1:0] execute_bpredictor_data,
   output logic [META_W-1:0] execute_bpredictor_meta,
   output logic              fetch_redirect,
   output logic [31:0]       fetch_redirect_PC,
   output logic              err_underflow,
   output logic              err_overflow,
   output logic [31:0]       stats_resolved,
   output logic [31:0]       stats_miss
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   typedef struct packed {
      logic [31:0]       pc4;
      logic [31:0]       p_target;
      logic              p_dir;
      logic [DATA_W-1:0] data;
      logic [META_W-1:0] meta;
   } entry_t;

   entry_t         mem [DEPTH];
   entry_t         head_ent;
   entry_t         push_ent;
   logic [PTR_W:0] head, tail, head_inc, tail_inc;
   logic           empty, full, pop, miss, push_acc, overflow_evt, underflow_evt;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty    = (head == tail);
   assign full     = (head[PTR_W] != tail[PTR_W]) && (head[PTR_W-1:0] == tail[PTR_W-1:0]);
   assign head_inc = head + PTR_ONE;
   assign tail_inc = tail + PTR_ONE;

   assign head_ent = mem[head[PTR_W-1:0]];
   assign push_ent = '{pc4: fetch_PC4, p_target: fetch_p_target, p_dir: fetch_p_dir,
                       data: fetch_data, meta: fetch_meta};

   assign pop  = exe_resolve & ~empty;
   assign miss = pop & ((exe_dir != head_ent.p_dir) |
                        (exe_dir & (exe_target != head_ent.p_target)));

   // A push while full is only taken when a non-miss pop frees the head slot this cycle;
   // a miss flushes everything younger, so a same-cycle push is wrong-path and discarded.
   assign push_acc      = fetch_push & ~miss & (~full | pop);
   assign overflow_evt  = fetch_push & full & ~push_acc;
   assign underflow_evt = exe_resolve & empty;

   assign queue_full = full;

   // Storage needs no reset: validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push_acc) mem[tail[PTR_W-1:0]] <= push_ent;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (pop) head <= head_inc;
         if (miss)          tail <= head_inc;
         else if (push_acc) tail <= tail_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         execute_bpredictor_update      <= 1'b0;
         execute_bpredictor_dir         <= 1'b0;
         execute_bpredictor_miss        <= 1'b0;
         execute_bpredictor_recover_ras <= 1'b0;
         execute_bpredictor_PC4         <= '0;
         execute_bpredictor_target      <= '0;
         execute_bpredictor_data        <= '0;
         execute_bpredictor_meta        <= '0;
         fetch_redirect                 <= 1'b0;
         fetch_redirect_PC              <= '0;
         err_underflow                  <= 1'b0;
         err_overflow                   <= 1'b0;
      end else begin
         execute_bpredictor_update <= pop;
         fetch_redirect            <= miss;
         if (pop) begin
            execute_bpredictor_dir         <= exe_dir;
            execute_bpredictor_miss        <= miss;
            execute_bpredictor_recover_ras <= miss;
            execute_bpredictor_PC4         <= head_ent.pc4;
            execute_bpredictor_target      <= exe_target;
            execute_bpredictor_data        <= head_ent.data;
            execute_bpredictor_meta        <= head_ent.meta;
         end
         if (miss) fetch_redirect_PC <= exe_dir ? exe_target : head_ent.pc4;
         if (underflow_evt) err_underflow <= 1'b1;
         if (overflow_evt)  err_overflow  <= 1'b1;
      end
   end

`ifdef BPRED_UQ_STATS_EN
   logic [31:0] resolved_cnt, miss_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resolved_cnt <= '0;
         miss_cnt     <= '0;
      end else begin
         if (pop)  resolved_cnt <= resolved_cnt + 32'd1;
         if (miss) miss_cnt     <= miss_cnt + 32'd1;
      end
   end

   assign stats_resolved = resolved_cnt;
   assign stats_miss     = miss_cnt;
`else
   assign stats_resolved = '0;
   assign stats_miss     = '0;
`endif

endmodule

// File: tb/tb_bpred_update_queue.sv
// Purpose : directed bench for bpred_update_queue with a reference FIFO model and a
//           queue of expected updates popped when the DUT pulses its update strobe.
// Ports   : drives every DUT port; DEPTH=8, DATA_W=96, META_W=4.
module tb_bpred_update_queue;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_push = 1'b0;
   logic [31:0] fetch_PC4 = '0, fetch_p_target = '0;
   logic        fetch_p_dir = 1'b0;
   logic [95:0] fetch_data = '0;
   logic [3:0]  fetch_meta = '0;
   logic        queue_full;
   logic        exe_resolve = 1'b0, exe_dir = 1'b0;
   logic [31:0] exe_target = '0;
   logic        upd, upd_dir, upd_miss, upd_ras;
   logic [31:0] upd_pc4, upd_tgt;
   logic [95:0] upd_data;
   logic [3:0]  upd_meta;
   logic        fetch_redirect;
   logic [31:0] fetch_redirect_PC;
   logic        err_underflow, err_overflow;
   logic [31:0] stats_resolved, stats_miss;

   bpred_update_queue #(.DEPTH(DEPTH), .DATA_W(96), .META_W(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_push(fetch_push), .fetch_PC4(fetch_PC4), .fetch_p_target(fetch_p_target),
      .fetch_p_dir(fetch_p_dir), .fetch_data(fetch_data), .fetch_meta(fetch_meta),
      .queue_full(queue_full),
      .exe_resolve(exe_resolve), .exe_dir(exe_dir), .exe_target(exe_target),
      .execute_bpredictor_update(upd), .execute_bpredictor_dir(upd_dir),
      .execute_bpredictor_miss(upd_miss), .execute_bpredictor_recover_ras(upd_ras),
      .execute_bpredictor_PC4(upd_pc4), .execute_bpredictor_target(upd_tgt),
      .execute_bpredictor_data(upd_data), .execute_bpredictor_meta(upd_meta),
      .fetch_redirect(fetch_redirect), .fetch_redirect_PC(fetch_redirect_PC),
      .err_underflow(err_underflow), .err_overflow(err_overflow),
      .stats_resolved(stats_resolved), .stats_miss(stats_miss)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] tgt;
      logic        dir;
      logic [95:0] data;
      logic [3:0]  meta;
   } ent_t;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] tgt;
      logic        dir;
      logic [95:0] data;
      logic [3:0]  meta;
      logic        miss;
      logic [31:0] rpc;
   } exp_t;

   ent_t        model_q[$];
   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   bit          exp_uf = 0, exp_of = 0;
   logic [31:0] last_pc4 = '0, last_rpc = '0;
   int unsigned n_res = 0, n_miss = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_stats();
`ifdef BPRED_UQ_STATS_EN
      chk("stats_resolved", 128'(stats_resolved), 128'(n_res));
      chk("stats_miss", 128'(stats_miss), 128'(n_miss));
`else
      chk("stats_resolved", 128'(stats_resolved), 128'(0));
      chk("stats_miss", 128'(stats_miss), 128'(0));
`endif
   endtask

   // rk: 0 = no resolve, 1 = correct, 2 = flipped direction, 3 = taken with wrong target
   task automatic step(input bit push, input logic [31:0] pc4, input logic pdir,
                       input logic [31:0] ptgt, input int rk);
      ent_t        h, e;
      exp_t        x;
      bit          full_m, empty_m, pop_m, miss_m;
      logic        edir;
      logic [31:0] etgt;
      full_m  = (model_q.size() == DEPTH);
      empty_m = (model_q.size() == 0);
      edir = 1'b1; etgt = 32'h0; pop_m = 0; miss_m = 0; h = '0;
      if (!empty_m) begin
         h = model_q[0];
         case (rk)
            1: begin edir = h.dir;  etgt = h.tgt; end
            2: begin edir = ~h.dir; etgt = h.tgt; end
            3: begin edir = 1'b1;   etgt = h.tgt ^ 32'h40; end
            default: ;
         endcase
      end
      pop_m = (rk != 0) && !empty_m;
      if (pop_m) begin
         miss_m = (edir != h.dir) || (edir && (etgt != h.tgt));
         x = '{pc4: h.pc4, tgt: etgt, dir: edir, data: h.data, meta: h.meta,
               miss: miss_m, rpc: (edir ? etgt : h.pc4)};
         exp_q.push_back(x);
         h = model_q.pop_front();
         if (miss_m) model_q.delete();
         n_res++;
         if (miss_m) n_miss++;
      end
      if (rk != 0 && empty_m) exp_uf = 1;
      e = '{pc4: pc4, tgt: ptgt, dir: pdir, data: {$urandom(), $urandom(), $urandom()},
            meta: 4'($urandom_range(15))};
      if (push) begin
         if (!miss_m && (!full_m || pop_m)) model_q.push_back(e);
         else if (full_m) exp_of = 1;
      end
      fetch_push = push; fetch_PC4 = e.pc4; fetch_p_target = e.tgt; fetch_p_dir = e.dir;
      fetch_data = e.data; fetch_meta = e.meta;
      exe_resolve = (rk != 0); exe_dir = edir; exe_target = etgt;
      @(posedge clk); #1;
      fetch_push = 1'b0; exe_resolve = 1'b0;
      chk("update", 128'(upd), 128'(pop_m));
      if (pop_m) begin
         x = exp_q.pop_front();
         chk("upd_data", 128'(upd_data), 128'(x.data));
         chk("upd_meta", 128'(upd_meta), 128'(x.meta));
         chk("upd_dir", 128'(upd_dir), 128'(x.dir));
         chk("upd_target", 128'(upd_tgt), 128'(x.tgt));
         chk("upd_miss", 128'(upd_miss), 128'(x.miss));
         chk("recover_ras", 128'(upd_ras), 128'(x.miss));
         chk("redirect", 128'(fetch_redirect), 128'(x.miss));
         last_pc4 = x.pc4;
         if (x.miss) last_rpc = x.rpc;
      end else begin
         chk("redirect_idle", 128'(fetch_redirect), 128'(0));
      end
      chk("upd_pc4", 128'(upd_pc4), 128'(last_pc4));
      chk("redirect_pc", 128'(fetch_redirect_PC), 128'(last_rpc));
      chk("queue_full", 128'(queue_full), 128'(model_q.size() == DEPTH));
      chk("err_underflow", 128'(err_underflow), 128'(exp_uf));
      chk("err_overflow", 128'(err_overflow), 128'(exp_of));
      chk_stats();
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_update", 128'(upd), 128'(0));
      chk("rst_full", 128'(queue_full), 128'(0));
      chk("rst_redirect", 128'(fetch_redirect), 128'(0));
      chk("rst_uf", 128'(err_underflow), 128'(0));
      chk("rst_of", 128'(err_overflow), 128'(0));
      reset = 1'b1;

      // Correct taken prediction, push on first edge after reset
      step(1, 32'h80, 1'b1, 32'h100, 0);
      step(0, 32'h0, 1'b0, 32'h0, 1);
      // Taken with wrong target: redirect to actual target
      step(1, 32'h90, 1'b1, 32'h180, 0);
      step(0, 32'h0, 1'b0, 32'h0, 3);
      step(0, 32'h0, 1'b0, 32'h0, 0);

      // Three entries, direction mispredict on the first, with a same-cycle push discarded
      step(1, 32'h200, 1'b1, 32'h300, 0);
      step(1, 32'h204, 1'b1, 32'h304, 0);
      step(1, 32'h208, 1'b0, 32'h308, 0);
      step(1, 32'h20c, 1'b1, 32'h30c, 2);
      // Queue now empty: resolve is ignored and underflow latches
      step(0, 32'h0, 1'b0, 32'h0, 1);
      step(0, 32'h0, 1'b0, 32'h0, 0);

      // Fill to DEPTH, overflow on the next push, then push+resolve while full
      for (int i = 0; i < DEPTH; i++) step(1, 32'h400 + 32'(i * 4), i[0], 32'h500 + 32'(i), 0);
      step(1, 32'h4f0, 1'b1, 32'h5f0, 0);
      step(1, 32'h4f4, 1'b0, 32'h5f4, 1);
      for (int i = 0; i < DEPTH; i++) step(0, 32'h0, 1'b0, 32'h0, 1);

      // Reset while holding 5 entries with an update pending
      for (int i = 0; i < 5; i++) step(1, 32'h600 + 32'(i * 4), 1'b1, 32'h700, 0);
      step(1, 32'h614, 1'b1, 32'h700, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_update", 128'(upd), 128'(0));
      chk("mid_rst_pc4", 128'(upd_pc4), 128'(0));
      chk("mid_rst_data", 128'(upd_data), 128'(0));
      chk("mid_rst_full", 128'(queue_full), 128'(0));
      chk("mid_rst_of", 128'(err_overflow), 128'(0));
      chk("mid_rst_uf", 128'(err_underflow), 128'(0));
      chk("mid_rst_rpc", 128'(fetch_redirect_PC), 128'(0));
      model_q.delete(); exp_q.delete();
      exp_uf = 0; exp_of = 0; last_pc4 = '0; last_rpc = '0; n_res = 0; n_miss = 0;
      chk_stats();
      @(posedge clk); #1;
      reset = 1'b1;
      // Queue must be empty after reset
      step(0, 32'h0, 1'b0, 32'h0, 1);

      // 20 entries interleaved with resolves, pointers wrap twice
      for (int i = 0; i < 20; i++)
         step(1, 32'h1000 + 32'(i * 4), i[1], 32'h2000 + 32'(i * 8), (i >= 2) ? 1 : 0);
      step(0, 32'h0, 1'b0, 32'h0, 1);
      step(0, 32'h0, 1'b0, 32'h0, 1);
`ifdef BPRED_UQ_STATS_EN
      chk("stats_twenty", 128'(stats_resolved), 128'(20));
`else
      chk("stats_tied", 128'(stats_resolved), 128'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bpred_update_queue.md
BPRED_UPDATE_QUEUE -- requirements
Module: bpred_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, in-flight branch entries (power of 2, 2..32).
REQ-002 SHALL have parameter DATA_W, default 96, predictor side-data width.
REQ-003 SHALL have parameter META_W, default 4, predictor meta width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 fetch_push  in  1  predicted branch enters queue.
REQ-007 fetch_PC4 / fetch_p_target  in  32 each  branch PC+4, predicted target.
REQ-008 fetch_p_dir  in  1  predicted direction (1 = taken).
REQ-009 fetch_data / fetch_meta  in  DATA_W / META_W  predictor state captured at prediction time.
REQ-010 queue_full  out  1  no free entry.
REQ-011 exe_resolve  in  1  oldest branch resolved this cycle.
REQ-012 exe_dir / exe_target  in  1 / 32  actual direction, actual target.
REQ-013 execute_bpredictor_update, _dir, _miss, _recover_ras  out  1 each  update strobe and fields to predictor.
REQ-014 execute_bpredictor_PC4, _target  out  32 each; execute_bpredictor_data  out  DATA_W; execute_bpredictor_meta  out  META_W.
REQ-015 fetch_redirect  out  1; fetch_redirect_PC  out  32  front-end redirect on mispredict.
REQ-016 err_underflow, err_overflow  out  1 each  sticky error flags.

Function
REQ-017 Entries SHALL be held in a circular buffer with head/tail pointers of log2(DEPTH) bits plus one wrap bit; full = pointers equal except wrap bit; empty = all bits equal.
REQ-018 fetch_push with queue_full=0 SHALL write entry at tail and advance tail; with queue_full=1 the push SHALL be dropped and err_overflow set.
REQ-019 Push and exe_resolve in the same cycle while full SHALL be accepted only if the resolve is not a miss.
REQ-020 exe_resolve with queue non-empty SHALL pop head; with queue empty it SHALL be ignored and err_underflow set.
REQ-021 miss SHALL be (exe_dir != p_dir) OR (exe_dir AND exe_target != p_target).
REQ-022 All execute_bpredictor_* outputs SHALL be registered: update pulses exactly one cycle after a valid pop, for one cycle, carrying popped PC4/data/meta, exe_dir, exe_target, computed miss.
REQ-023 execute_bpredictor_recover_ras SHALL equal miss for that update.
REQ-024 On miss, same registered cycle, fetch_redirect SHALL pulse one cycle with fetch_redirect_PC = exe_dir ? exe_target : PC4.
REQ-025 On miss, all remaining entries SHALL be flushed (tail := head after pop) and any push in the same cycle discarded.
REQ-026 Outputs other than strobes SHALL hold last value when no update.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL toggle the wrap bit; no entry lost at wrap.

Reset
REQ-028 reset low SHALL immediately empty the queue, clear all outputs and error flags to 0, including mid-update; queue_full=0.
REQ-029 First push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 With BPRED_UQ_STATS_EN defined, SHALL add outputs stats_resolved and stats_miss (32-bit, wrap at 2^32) counting valid pops and misses, cleared by reset.
REQ-031 Without BPRED_UQ_STATS_EN, those ports SHALL be present and tied to 0; no counter logic.

Verification
REQ-032 Push PC4=0x80, p_dir=1, p_target=0x100; resolve dir=1,target=0x100 -> next cycle update=1, miss=0, fetch_redirect=0.
REQ-033 Push 3 entries, resolve first with dir=0 against p_dir=1 -> miss=1, recover_ras=1, fetch_redirect_PC=PC4 of first, queue empty after.
REQ-034 Push 8 with DEPTH=8 -> queue_full=1; 9th push dropped, err_overflow=1; 8 correct resolves return entries in push order.
REQ-035 Resolve on empty queue -> no update pulse, err_underflow=1, sticky until reset.
REQ-036 Drive reset low while queue holds 5 entries and update pending -> all outputs 0 immediately, queue empty; with BPRED_UQ_STATS_EN counters 0.
REQ-037 Push 20 entries interleaved with resolves (wrap twice) -> every update PC4 matches push order; stats_resolved=20 when enabled.
